// File: rtl/time_base_multi.sv
// Baseband time base: sample clock enables, preTIC/TIC and ACCUM_INT strobes with
// double-buffered divides and software resync. TB_PPS_ALIGN_EN adds a PPS-driven resync.
module time_base_multi #(
  parameter int CNT_W            = 24,
  parameter int SC_DIV           = 7,
  parameter int ACC_SAMPLE_PHASE = 3,
  parameter int TIC_DELAY        = 1,
  parameter int SEQ_W            = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] tic_divide,
  input  logic [CNT_W-1:0] accum_divide,
  input  logic             div_load,
  input  logic             resync,
`ifdef TB_PPS_ALIGN_EN
  input  logic             pps_in,
`endif
  output logic             sample_clk,
  output logic             accum_sample_enable,
  output logic             pre_tic_enable,
  output logic             tic_enable,
  output logic             accum_enable,
  output logic [CNT_W-1:0] tic_count,
  output logic [CNT_W-1:0] accum_count,
  output logic [SEQ_W-1:0] tic_seq,
  output logic [1:0]       div_pending
);

  localparam int SDIV_W = (SC_DIV > 2) ? $clog2(SC_DIV) : 1;

  logic [SDIV_W-1:0]    sdiv_q, sdiv_d;
  logic [CNT_W-1:0]     tic_q, tic_d, acc_q, acc_d;
  logic [CNT_W-1:0]     tic_act_q, tic_act_d, tic_shd_q, tic_shd_d;
  logic [CNT_W-1:0]     acc_act_q, acc_act_d, acc_shd_q, acc_shd_d;
  logic [TIC_DELAY-1:0] dly_q, dly_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [1:0]           pend_q, pend_d;
  logic                 tc_tic, tc_acc, rsync;

`ifdef TB_PPS_ALIGN_EN
  // Two synchroniser stages plus one history stage; the registered rise pulse
  // lands three cycles after the pin edge.
  logic [2:0] pps_sync_q, pps_sync_d;
  logic       pps_rise_q, pps_rise_d;

  always_comb begin
    pps_sync_d = {pps_sync_q[1:0], pps_in};
    pps_rise_d = pps_sync_q[1] & ~pps_sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pps_sync_q <= '0;
      pps_rise_q <= 1'b0;
    end else begin
      pps_sync_q <= pps_sync_d;
      pps_rise_q <= pps_rise_d;
    end
  end

  assign rsync = resync | pps_rise_q;
`else
  assign rsync = resync;
`endif

  assign tc_tic = (tic_q == '0);
  assign tc_acc = (acc_q == '0);

  always_comb begin
    sdiv_d    = (sdiv_q == SDIV_W'(SC_DIV - 1)) ? '0 : sdiv_q + SDIV_W'(1);
    dly_d     = (dly_q << 1) | TIC_DELAY'(tc_tic);
    tic_act_d = tic_act_q;
    acc_act_d = acc_act_q;
    tic_shd_d = tic_shd_q;
    acc_shd_d = acc_shd_q;
    pend_d    = pend_q;
    seq_d     = dly_q[TIC_DELAY-1] ? seq_q + SEQ_W'(1) : seq_q;
    tic_d     = tic_q - CNT_W'(1);
    acc_d     = acc_q - CNT_W'(1);

    // A pending shadow is promoted at terminal count and feeds that same reload.
    if (tc_tic) begin
      tic_d = pend_q[0] ? tic_shd_q : tic_act_q;
      if (pend_q[0]) begin
        tic_act_d = tic_shd_q;
        pend_d[0] = 1'b0;
      end
    end
    if (tc_acc) begin
      acc_d = pend_q[1] ? acc_shd_q : acc_act_q;
      if (pend_q[1]) begin
        acc_act_d = acc_shd_q;
        pend_d[1] = 1'b0;
      end
    end

    // Load after promotion so a same-cycle load stays pending for the next reload.
    if (div_load) begin
      tic_shd_d = tic_divide;
      acc_shd_d = accum_divide;
      pend_d    = 2'b11;
    end

    if (rsync) begin
      sdiv_d    = '0;
      tic_d     = '0;
      acc_d     = '0;
      dly_d     = '0;
      tic_act_d = tic_act_q;
      acc_act_d = acc_act_q;
      tic_shd_d = tic_shd_q;
      acc_shd_d = acc_shd_q;
      pend_d    = pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sdiv_q    <= '0;
      tic_q     <= '0;
      acc_q     <= '0;
      dly_q     <= '0;
      seq_q     <= '0;
      pend_q    <= '0;
      tic_act_q <= tic_divide;
      tic_shd_q <= tic_divide;
      acc_act_q <= accum_divide;
      acc_shd_q <= accum_divide;
    end else begin
      sdiv_q    <= sdiv_d;
      tic_q     <= tic_d;
      acc_q     <= acc_d;
      dly_q     <= dly_d;
      seq_q     <= seq_d;
      pend_q    <= pend_d;
      tic_act_q <= tic_act_d;
      tic_shd_q <= tic_shd_d;
      acc_act_q <= acc_act_d;
      acc_shd_q <= acc_shd_d;
    end
  end

  assign sample_clk          = rstn & (sdiv_q == '0);
  assign accum_sample_enable = rstn & (sdiv_q == SDIV_W'(ACC_SAMPLE_PHASE));
  assign pre_tic_enable      = rstn & tc_tic;
  assign tic_enable          = rstn & dly_q[TIC_DELAY-1];
  assign accum_enable        = rstn & tc_acc;
  assign tic_count           = tic_q;
  assign accum_count         = acc_q;
  assign tic_seq             = seq_q;
  assign div_pending         = pend_q;

endmodule

// File: tb/tb_time_base_multi.sv
// Scoreboard bench for time_base_multi: per-cycle strobe expectations derived from
// event-cycle lists are queued at drive time and compared at the following negedge.
module tb_time_base_multi;
  localparam int CNT_W = 24;
  localparam int SEQ_W = 16;
  localparam int TD    = 3;
  localparam int SCD   = 7;
  localparam int ASP   = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [CNT_W-1:0] tic_divide = '0, accum_divide = '0;
  logic             div_load = 1'b0, resync = 1'b0;
  logic             sample_clk, accum_sample_enable, pre_tic_enable, tic_enable, accum_enable;
  logic [CNT_W-1:0] tic_count, accum_count;
  logic [SEQ_W-1:0] tic_seq;
  logic [1:0]       div_pending;
`ifdef TB_PPS_ALIGN_EN
  logic             pps_in = 1'b0;
`endif

  time_base_multi #(.CNT_W(CNT_W), .SC_DIV(SCD), .ACC_SAMPLE_PHASE(ASP),
                    .TIC_DELAY(TD), .SEQ_W(SEQ_W)) u_dut (
    .clk(clk), .rstn(rstn), .tic_divide(tic_divide), .accum_divide(accum_divide),
    .div_load(div_load), .resync(resync),
`ifdef TB_PPS_ALIGN_EN
    .pps_in(pps_in),
`endif
    .sample_clk(sample_clk), .accum_sample_enable(accum_sample_enable),
    .pre_tic_enable(pre_tic_enable), .tic_enable(tic_enable), .accum_enable(accum_enable),
    .tic_count(tic_count), .accum_count(accum_count), .tic_seq(tic_seq),
    .div_pending(div_pending));

  always #5 clk = ~clk;

  typedef struct { string tag; logic [4:0] exp; } sb_t;
  sb_t sb_q[$];

  int n_chk = 0, n_err = 0;
  int cyc, sc_base, rs_cyc;
  int pt_q[$], ae_q[$];
  logic [1:0]       pend_log [0:63];
  logic [SEQ_W-1:0] seq_log  [0:63];
  logic [CNT_W-1:0] tcnt_log [0:63];
  logic [CNT_W-1:0] acnt_log [0:63];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic bit in_list(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // TIC follows preTIC by TD cycles unless a resync flushed the delay line meanwhile.
  function automatic bit exp_te(input int c);
    int p;
    p = c - TD;
    if (p < 0) return 1'b0;
    return in_list(pt_q, p) && !(rs_cyc >= p && rs_cyc <= p + TD - 1);
  endfunction

  function automatic logic [4:0] exp_vec(input int c);
    bit sc, ase;
    sc  = (c >= sc_base) && (((c - sc_base) % SCD) == 0);
    ase = (c >= sc_base) && (((c - sc_base) % SCD) == ASP);
    return {sc, ase, in_list(pt_q, c), exp_te(c), in_list(ae_q, c)};
  endfunction

  task automatic do_reset(input logic [CNT_W-1:0] td, input logic [CNT_W-1:0] ad);
    @(posedge clk); #1;
    rstn = 1'b0; tic_divide = td; accum_divide = ad; div_load = 1'b0; resync = 1'b0;
`ifdef TB_PPS_ALIGN_EN
    pps_in = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {27'b0, sample_clk, accum_sample_enable, pre_tic_enable,
                          tic_enable, accum_enable}, 32'h0);
    check("rst_seq", {16'b0, tic_seq}, 32'h0);
    check("rst_pend", {30'b0, div_pending}, 32'h0);
    check("rst_tcnt", {8'b0, tic_count}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1; cyc = 0; sc_base = 0; rs_cyc = -100;
    pt_q.delete(); ae_q.delete();
  endtask

  task automatic run_scn(input string tag, input int n, input int ld_c,
                         input logic [CNT_W-1:0] ld_v, input int rs_c, input bit rs_pin);
    sb_t e;
    rs_cyc = rs_c;
    for (int i = 0; i < n; i++) begin
      if (cyc == ld_c) begin div_load = 1'b1; tic_divide = ld_v; end
      if (cyc == rs_c && !rs_pin) resync = 1'b1;
`ifdef TB_PPS_ALIGN_EN
      if (rs_pin && cyc == rs_c - 3) pps_in = 1'b1;
`endif
      e.tag = tag; e.exp = exp_vec(cyc);
      sb_q.push_back(e);
      if (cyc == rs_c) sc_base = cyc + 1;
      @(negedge clk);
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s_c%0d", e.tag, cyc),
              {27'b0, sample_clk, accum_sample_enable, pre_tic_enable, tic_enable, accum_enable},
              {27'b0, e.exp});
      end
      if (cyc < 64) begin
        pend_log[cyc] = div_pending; seq_log[cyc] = tic_seq;
        tcnt_log[cyc] = tic_count;   acnt_log[cyc] = accum_count;
      end
      @(posedge clk); #1;
      div_load = 1'b0; resync = 1'b0; cyc++;
    end
  endtask

  initial begin
    // Free-running from reset: tic period 10, accum period 5.
    do_reset(24'd9, 24'd4);
    pt_q = '{0, 10, 20};
    ae_q = '{0, 5, 10, 15, 20, 25};
    run_scn("free", 30, -1, '0, -100, 1'b0);
    check("free_tcnt1", {8'b0, tcnt_log[1]}, 32'd9);
    check("free_acnt1", {8'b0, acnt_log[1]}, 32'd4);
    check("free_acnt2", {8'b0, acnt_log[2]}, 32'd3);
    check("free_seq29", {16'b0, seq_log[29]}, 32'd3);

    // Reload mid-period: new divide takes effect at the next terminal count.
    do_reset(24'd9, 24'd4);
    pt_q = '{0, 10, 15, 20, 25};
    ae_q = '{0, 5, 10, 15, 20, 25};
    run_scn("ld3", 28, 3, 24'd4, -100, 1'b0);
    check("ld3_pend3",  {30'b0, pend_log[3]},  32'h0);
    check("ld3_pend4",  {30'b0, pend_log[4]},  32'h3);
    check("ld3_pend8",  {30'b0, pend_log[8]},  32'h1);
    check("ld3_pend11", {30'b0, pend_log[11]}, 32'h0);

    // Reload on a terminal-count cycle: old value used once more.
    do_reset(24'd9, 24'd4);
    pt_q = '{0, 10, 20, 25};
    ae_q = '{0, 5, 10, 15, 20, 25};
    run_scn("ld10", 28, 10, 24'd4, -100, 1'b0);
    check("ld10_pend11", {30'b0, pend_log[11]}, 32'h3);
    check("ld10_pend16", {30'b0, pend_log[16]}, 32'h1);
    check("ld10_pend21", {30'b0, pend_log[21]}, 32'h0);
    check("ld10_tcnt11", {8'b0, tcnt_log[11]}, 32'd9);

    // Resync after the delayed TIC has already gone out.
    do_reset(24'd9, 24'd4);
    pt_q = '{0, 7, 17};
    ae_q = '{0, 5, 7, 12, 17, 22};
    run_scn("rs6", 24, -1, '0, 6, 1'b0);
    check("rs6_seq7",  {16'b0, seq_log[7]},  32'd1);
    check("rs6_seq23", {16'b0, seq_log[23]}, 32'd3);

    // Resync while the first preTIC is still in the delay line.
    do_reset(24'd9, 24'd4);
    pt_q = '{0, 2, 12};
    ae_q = '{0, 2, 7, 12, 17};
    run_scn("rs1", 20, -1, '0, 1, 1'b0);
    check("rs1_seq4",  {16'b0, seq_log[4]},  32'd0);
    check("rs1_seq19", {16'b0, seq_log[19]}, 32'd2);

`ifdef TB_PPS_ALIGN_EN
    // PPS edge at cycle 20 behaves as resync at cycle 23; held level does nothing more.
    do_reset(24'd9, 24'd4);
    pt_q = '{0, 10, 20, 24, 34};
    ae_q = '{0, 5, 10, 15, 20, 24, 29, 34, 39};
    run_scn("pps", 42, -1, '0, 23, 1'b1);
    check("pps_tcnt24", {8'b0, tcnt_log[24]}, 32'd0);
`endif

    // Divide of zero: strobe every cycle, sequence counter wraps.
    do_reset(24'd0, 24'd4);
    for (int i = 0; i < 20; i++) pt_q.push_back(i);
    ae_q = '{0, 5, 10, 15};
    run_scn("div0", 20, -1, '0, -100, 1'b0);
    check("div0_seq10", {16'b0, seq_log[10]}, 32'd7);
    while (cyc < 65538) begin
      @(posedge clk); #1; cyc++;
    end
    @(negedge clk);
    check("div0_seq_max", {16'b0, tic_seq}, 32'hFFFF);
    check("div0_pt", {31'b0, pre_tic_enable}, 32'h1);
    @(posedge clk); #1; cyc++;
    @(negedge clk);
    check("div0_seq_wrap", {16'b0, tic_seq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
